// File: rtl/axi_lite_mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axi_lite_mem_pkg: AXI4-Lite channel types shared with the bridge    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package axi_lite_mem_pkg;

  localparam int unsigned AXI_ADDR_WIDTH = 32;
  localparam int unsigned AXI_DATA_WIDTH = 32;

  typedef logic [AXI_ADDR_WIDTH-1:0]   axi_lite_addr_t;
  typedef logic [AXI_DATA_WIDTH-1:0]   axi_lite_data_t;
  typedef logic [AXI_DATA_WIDTH/8-1:0] axi_lite_strb_t;

  typedef struct packed {
    axi_lite_addr_t addr;
    logic [2:0]     prot;
  } axi_aw_chan_t;

  typedef struct packed {
    axi_lite_data_t data;
    axi_lite_strb_t strb;
  } axi_w_chan_t;

  typedef struct packed {
    logic [1:0] resp;
  } axi_b_chan_t;

  typedef struct packed {
    axi_lite_addr_t addr;
    logic [2:0]     prot;
  } axi_ar_chan_t;

  typedef struct packed {
    axi_lite_data_t data;
    logic [1:0]     resp;
  } axi_r_chan_t;

  typedef struct packed {
    axi_aw_chan_t aw;
    logic         aw_valid;
    axi_w_chan_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_ar_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } axi_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        w_ready;
    axi_b_chan_t b;
    logic        b_valid;
    logic        ar_ready;
    axi_r_chan_t r;
    logic        r_valid;
  } axi_resp_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MEM_REQ  = 3'd1,
    ST_MEM_WAIT = 3'd2,
    ST_B_RESP   = 3'd3,
    ST_R_RESP   = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/axi_lite_to_mem_slave_slot.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axi_lite_slot: one-entry holding register for an AXI address/data   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module axi_lite_slot #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             clear_i,
  output logic             full_o,
  output logic [WIDTH-1:0] data_o
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (clear_i) begin
      full_d = 1'b0;
    end else if (valid_i && !full_q) begin
      full_d = 1'b1;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule
`default_nettype wire

// File: rtl/axi_lite_to_mem_slave.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axi_lite_to_mem_slave: AXI4-Lite slave onto a req/gnt/rvalid port   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module axi_lite_to_mem_slave
  import axi_lite_mem_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] SIZE_BYTES = 32'h0001_0000
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  axi_req_t                axi_req_i,
  output axi_resp_t               axi_resp_o,
  output logic                    mem_req_o,
  input  logic                    mem_gnt_i,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  state_e                  state_q, state_d;
  logic                    active_q, active_d;
  logic                    prio_wr_q, prio_wr_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [BE_WIDTH-1:0]     be_q, be_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [1:0]              b_resp_q, b_resp_d;
  logic [1:0]              r_resp_q, r_resp_d;
  logic [DATA_WIDTH-1:0]   r_data_q, r_data_d;

  logic                    aw_full, w_full, slot_clear;
  logic [ADDR_WIDTH-1:0]   aw_addr, ar_addr;
  logic [BE_WIDTH-1:0]     w_strb;
  logic [DATA_WIDTH-1:0]   w_data;
  logic                    write_pending, rd_req, ar_ready;
  logic                    unused_prot;

  assign unused_prot = ^{axi_req_i.aw.prot, axi_req_i.ar.prot};
  assign ar_addr     = ADDR_WIDTH'(axi_req_i.ar.addr);

  // Ready stays low until the first clock after reset release.
  axi_lite_slot #(.WIDTH(ADDR_WIDTH)) u_aw_slot (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (axi_req_i.aw_valid & active_q),
    .data_i  (ADDR_WIDTH'(axi_req_i.aw.addr)),
    .clear_i (slot_clear),
    .full_o  (aw_full),
    .data_o  (aw_addr)
  );

  axi_lite_slot #(.WIDTH(DATA_WIDTH + BE_WIDTH)) u_w_slot (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (axi_req_i.w_valid & active_q),
    .data_i  ({axi_req_i.w.strb, axi_req_i.w.data}),
    .clear_i (slot_clear),
    .full_o  (w_full),
    .data_o  ({w_strb, w_data})
  );

  // Extra top bit keeps the offset subtraction from wrapping near the top of memory.
  function automatic logic in_window(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH:0] ext, base, offs;
    ext  = {1'b0, a};
    base = {1'b0, BASE_ADDR};
    offs = ext - base;
    return (ext >= base) && (offs < {1'b0, SIZE_BYTES});
  endfunction

  always_comb begin
    state_d       = state_q;
    active_d      = 1'b1;
    prio_wr_d     = prio_wr_q;
    we_d          = we_q;
    addr_d        = addr_q;
    be_d          = be_q;
    wdata_d       = wdata_q;
    b_resp_d      = b_resp_q;
    r_resp_d      = r_resp_q;
    r_data_d      = r_data_q;
    slot_clear    = 1'b0;
    ar_ready      = 1'b0;
    write_pending = aw_full & w_full;
    rd_req        = active_q & axi_req_i.ar_valid;

    case (state_q)
      ST_IDLE: begin
        if (write_pending && (!rd_req || prio_wr_q)) begin
          if (rd_req) prio_wr_d = 1'b0;
          if (in_window(aw_addr)) begin
            we_d    = 1'b1;
            addr_d  = {aw_addr[ADDR_WIDTH-1:2], 2'b00};
            be_d    = w_strb;
            wdata_d = w_data;
            state_d = ST_MEM_REQ;
          end else begin
            b_resp_d = RESP_SLVERR;
            state_d  = ST_B_RESP;
          end
        end else if (rd_req) begin
          ar_ready = 1'b1;
          if (write_pending) prio_wr_d = 1'b1;
          if (in_window(ar_addr)) begin
            we_d    = 1'b0;
            addr_d  = {ar_addr[ADDR_WIDTH-1:2], 2'b00};
            be_d    = '1;
            state_d = ST_MEM_REQ;
          end else begin
            r_resp_d = RESP_SLVERR;
            r_data_d = '0;
            state_d  = ST_R_RESP;
          end
        end
      end
      ST_MEM_REQ: begin
        if (mem_gnt_i) state_d = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        if (mem_rvalid_i) begin
          if (we_q) begin
            b_resp_d = RESP_OKAY;
            state_d  = ST_B_RESP;
          end else begin
            r_resp_d = RESP_OKAY;
            r_data_d = mem_rdata_i;
            state_d  = ST_R_RESP;
          end
        end
      end
      ST_B_RESP: begin
        if (axi_req_i.b_ready) begin
          slot_clear = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_R_RESP: begin
        if (axi_req_i.r_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      active_q  <= 1'b0;
      prio_wr_q <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      b_resp_q  <= '0;
      r_resp_q  <= '0;
      r_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      prio_wr_q <= prio_wr_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      b_resp_q  <= b_resp_d;
      r_resp_q  <= r_resp_d;
      r_data_q  <= r_data_d;
    end
  end

  always_comb begin
    axi_resp_o          = '0;
    axi_resp_o.aw_ready = active_q & ~aw_full;
    axi_resp_o.w_ready  = active_q & ~w_full;
    axi_resp_o.ar_ready = ar_ready;
    axi_resp_o.b_valid  = (state_q == ST_B_RESP);
    axi_resp_o.b.resp   = b_resp_q;
    axi_resp_o.r_valid  = (state_q == ST_R_RESP);
    axi_resp_o.r.resp   = r_resp_q;
    axi_resp_o.r.data   = r_data_q;
  end

  assign mem_req_o   = (state_q == ST_MEM_REQ);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_to_mem_slave.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_axi_lite_to_mem_slave: directed + random bench, memory model     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_axi_lite_to_mem_slave;
  import axi_lite_mem_pkg::*;

  logic        clk_i, rst_ni;
  axi_req_t    req;
  axi_resp_t   rsp;
  logic        mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_be_o;

  int total = 0;
  int bad   = 0;

  axi_lite_to_mem_slave #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .BASE_ADDR  (32'h0000_0000),
    .SIZE_BYTES (32'h0001_0000)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .axi_req_i    (req),
    .axi_resp_o   (rsp),
    .mem_req_o    (mem_req_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_be_o     (mem_be_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- memory device model ----------------
  logic [31:0] dev_mem [int unsigned];
  logic [31:0] ref_mem [int unsigned];
  int          gnt_stall = 0, rsp_delay = 1;
  int          n_accept = 0, req_cycles = 0, addr_unstable = 0;
  int          stall_cnt = 0, rsp_cnt = 0;
  logic        last_we;
  logic [31:0] last_addr, last_wdata, first_addr, pend_rdata;
  logic [3:0]  last_be;

  function automatic logic [31:0] init_pat(input logic [31:0] a);
    return ({a[31:2], 2'b00} * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] dev_read(input logic [31:0] a);
    if (dev_mem.exists(a >> 2)) return dev_mem[a >> 2];
    return init_pat(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (ref_mem.exists(a >> 2)) return ref_mem[a >> 2];
    return init_pat(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  initial begin
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = pend_rdata;
        end
      end
      if (mem_req_o) begin
        req_cycles++;
        if (stall_cnt == 0) first_addr = mem_addr_o;
        else if (mem_addr_o !== first_addr) addr_unstable++;
        if (stall_cnt < gnt_stall) begin
          stall_cnt++;
        end else begin
          mem_gnt_i  = 1'b1;
          stall_cnt  = 0;
          n_accept++;
          last_we    = mem_we_o;
          last_addr  = mem_addr_o;
          last_be    = mem_be_o;
          last_wdata = mem_wdata_o;
          if (mem_we_o) dev_mem[mem_addr_o >> 2] = merge(dev_read(mem_addr_o), mem_wdata_o, mem_be_o);
          else pend_rdata = dev_read(mem_addr_o);
          rsp_cnt = rsp_delay;
        end
      end
    end
  end

  // ---------------- AXI master tasks ----------------
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int b_stall,
                          output logic [1:0] resp, output int held);
    bit aw_done, w_done, aw_hs, w_hs;
    int cyc;
    aw_done = 0; w_done = 0; aw_hs = 0; w_hs = 0; cyc = 0; held = 0;
    while (!(aw_done && w_done) && cyc < 100) begin
      @(negedge clk_i);
      if (aw_hs) begin aw_done = 1; req.aw_valid = 1'b0; end
      if (w_hs)  begin w_done  = 1; req.w_valid  = 1'b0; end
      if (!aw_done && cyc >= aw_dly) begin
        req.aw.addr = a; req.aw.prot = 3'($urandom_range(0, 7)); req.aw_valid = 1'b1;
      end
      if (!w_done && cyc >= w_dly) begin
        req.w.data = d; req.w.strb = s; req.w_valid = 1'b1;
      end
      aw_hs = req.aw_valid && rsp.aw_ready;
      w_hs  = req.w_valid && rsp.w_ready;
      cyc++;
    end
    cyc = 0;
    while (!rsp.b_valid && cyc < 200) begin @(negedge clk_i); cyc++; end
    chk("b_valid_seen", rsp.b_valid, 1'b1);
    for (int i = 0; i < b_stall; i++) begin
      @(negedge clk_i);
      if (rsp.b_valid) held++;
    end
    resp = rsp.b.resp;
    req.b_ready = 1'b1;
    @(negedge clk_i);
    req.b_ready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input int r_stall,
                         output logic [31:0] data, output logic [1:0] resp,
                         output int lat, output bit stable);
    int cyc;
    logic [31:0] d0;
    logic [1:0]  r0;
    @(negedge clk_i);
    req.ar.addr = a; req.ar.prot = 3'($urandom_range(0, 7)); req.ar_valid = 1'b1;
    #1;
    cyc = 0;
    while (!rsp.ar_ready && cyc < 200) begin @(negedge clk_i); #1; cyc++; end
    chk("ar_ready_seen", rsp.ar_ready, 1'b1);
    @(negedge clk_i);
    req.ar_valid = 1'b0;
    lat = 1;
    while (!rsp.r_valid && lat < 200) begin @(negedge clk_i); lat++; end
    chk("r_valid_seen", rsp.r_valid, 1'b1);
    d0 = rsp.r.data; r0 = rsp.r.resp; stable = 1;
    for (int i = 0; i < r_stall; i++) begin
      @(negedge clk_i);
      if (!rsp.r_valid || rsp.r.data !== d0 || rsp.r.resp !== r0) stable = 0;
    end
    data = rsp.r.data; resp = rsp.r.resp;
    req.r_ready = 1'b1;
    @(negedge clk_i);
    req.r_ready = 1'b0;
  endtask

  // Write captured first, read raised once both slots are full, so both contend.
  task automatic arb_round(input logic [31:0] wa, input logic [31:0] wd, input logic [31:0] ra,
                           output int first_wr, output logic [1:0] bres, output logic [1:0] rres,
                           output logic [31:0] rdata);
    bit got_b, got_r, drop_ar;
    int n;
    got_b = 0; got_r = 0; drop_ar = 0; n = 0; first_wr = -1;
    @(negedge clk_i);
    req.aw.addr = wa; req.aw_valid = 1'b1;
    req.w.data = wd; req.w.strb = 4'hF; req.w_valid = 1'b1;
    chk("arb_slots_ready", {rsp.aw_ready, rsp.w_ready}, 2'b11);
    @(negedge clk_i);
    req.aw_valid = 1'b0; req.w_valid = 1'b0;
    req.ar.addr = ra; req.ar_valid = 1'b1;
    while (!(got_b && got_r) && n < 300) begin
      #1;
      if (req.ar_valid && rsp.ar_ready) drop_ar = 1;
      if (rsp.b_valid && !got_b) begin
        got_b = 1; bres = rsp.b.resp; req.b_ready = 1'b1;
        if (first_wr < 0) first_wr = 1;
      end
      if (rsp.r_valid && !got_r) begin
        got_r = 1; rres = rsp.r.resp; rdata = rsp.r.data; req.r_ready = 1'b1;
        if (first_wr < 0) first_wr = 0;
      end
      @(negedge clk_i);
      if (drop_ar) begin req.ar_valid = 1'b0; drop_ar = 0; end
      req.b_ready = 1'b0; req.r_ready = 1'b0;
      n++;
    end
    chk("arb_both_done", {got_b, got_r}, 2'b11);
  endtask

  // ---------------- main sequence ----------------
  logic [1:0]  resp;
  logic [31:0] data, a, d, exp_d;
  logic [3:0]  s;
  int          held, lat, acc0, req0, first_wr;
  bit          stable, is_wr, exp_hit;
  logic [1:0]  bres, rres;

  initial begin
    req = '0;
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("reset_axi_resp", rsp, '0);
    chk("reset_mem_outs", {mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o}, '0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // write hit, AW and W together
    acc0 = n_accept;
    do_write(32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, resp, held);
    chk("wr1_resp", resp, RESP_OKAY);
    chk("wr1_accepts", n_accept - acc0, 1);
    chk("wr1_mem", {last_we, last_addr, last_be, last_wdata}, {1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF});

    // W three cycles ahead of AW, B back-pressured
    acc0 = n_accept;
    do_write(32'h24, 32'h1234_5678, 4'h3, 3, 0, 4, resp, held);
    chk("wr2_resp", resp, RESP_OKAY);
    chk("wr2_accepts", n_accept - acc0, 1);
    chk("wr2_mem", {last_we, last_addr, last_be, last_wdata}, {1'b1, 32'h24, 4'h3, 32'h1234_5678});
    chk("wr2_b_held", held, 4);

    // minimum-latency read of the first write
    do_read(32'h10, 0, data, resp, lat, stable);
    chk("rd10_data", data, 32'hDEAD_BEEF);
    chk("rd10_latency", lat, 3);
    do_read(32'h26, 0, data, resp, lat, stable);
    chk("rd24_data", data, (init_pat(32'h24) & 32'hFFFF_0000) | 32'h0000_5678);

    // grant stall and R back-pressure
    dev_mem[32'h40 >> 2] = 32'hCAFE_F00D;
    gnt_stall = 2; acc0 = n_accept; addr_unstable = 0;
    do_read(32'h40, 2, data, resp, lat, stable);
    chk("rd40_accepts", n_accept - acc0, 1);
    chk("rd40_data", data, 32'hCAFE_F00D);
    chk("rd40_resp", resp, RESP_OKAY);
    chk("rd40_stable", stable, 1'b1);
    chk("rd40_addr_stable", addr_unstable, 0);
    chk("rd40_mem", {last_we, last_addr, last_be}, {1'b0, 32'h40, 4'hF});
    gnt_stall = 0;

    // out of window
    req0 = req_cycles;
    do_read(32'h0001_0000, 0, data, resp, lat, stable);
    chk("rdmiss_resp", resp, RESP_SLVERR);
    chk("rdmiss_data", data, 32'h0);
    do_write(32'hFFFF_FFFC, 32'h5555_AAAA, 4'hF, 0, 0, 1, resp, held);
    chk("wrmiss_resp", resp, RESP_SLVERR);
    chk("miss_no_mem_req", req_cycles - req0, 0);

    // round-robin between simultaneous write and read
    acc0 = n_accept;
    arb_round(32'h108, 32'hA1B2_C3D4, 32'h10C, first_wr, bres, rres, data);
    ref_mem[32'h108 >> 2] = 32'hA1B2_C3D4;
    chk("arb1_write_first", first_wr, 1);
    chk("arb1_resps", {bres, rres}, {RESP_OKAY, RESP_OKAY});
    chk("arb1_rdata", data, ref_read(32'h10C));
    chk("arb1_accepts", n_accept - acc0, 2);
    acc0 = n_accept;
    arb_round(32'h110, 32'h0F0F_1234, 32'h108, first_wr, bres, rres, data);
    chk("arb2_read_first", first_wr, 0);
    chk("arb2_rdata", data, ref_read(32'h108));
    ref_mem[32'h110 >> 2] = 32'h0F0F_1234;
    chk("arb2_accepts", n_accept - acc0, 2);

    // random traffic against a word-array model
    for (int t = 0; t < 40; t++) begin
      is_wr = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0:       a = 32'h0001_0000 + 32'($urandom_range(0, 255));
        1:       a = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
        default: a = 32'h100 + 32'($urandom_range(0, 63));
      endcase
      exp_hit   = (a < 32'h0001_0000);
      gnt_stall = $urandom_range(0, 3);
      rsp_delay = $urandom_range(1, 3);
      acc0      = n_accept;
      if (is_wr) begin
        d = $urandom; s = 4'($urandom_range(0, 15));
        do_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2), 1, resp, held);
        chk("rnd_wr_resp", resp, exp_hit ? RESP_OKAY : RESP_SLVERR);
        chk("rnd_wr_accepts", n_accept - acc0, exp_hit ? 1 : 0);
        if (exp_hit) begin
          chk("rnd_wr_mem", {last_we, last_addr, last_be, last_wdata}, {1'b1, a & 32'hFFFF_FFFC, s, d});
          ref_mem[a >> 2] = merge(ref_read(a), d, s);
        end
      end else begin
        do_read(a, $urandom_range(0, 2), data, resp, lat, stable);
        exp_d = exp_hit ? ref_read(a) : 32'h0;
        chk("rnd_rd_resp", resp, exp_hit ? RESP_OKAY : RESP_SLVERR);
        chk("rnd_rd_data", data, exp_d);
        chk("rnd_rd_stable", stable, 1'b1);
        chk("rnd_rd_accepts", n_accept - acc0, exp_hit ? 1 : 0);
      end
    end
    gnt_stall = 0;

    // reset while waiting for the memory response
    rsp_delay = 6;
    @(negedge clk_i);
    req.ar.addr = 32'h104; req.ar_valid = 1'b1;
    #1;
    chk("rst_ar_ready", rsp.ar_ready, 1'b1);
    @(negedge clk_i);
    req.ar_valid = 1'b0;
    @(negedge clk_i);
    chk("rst_pre_addr", {mem_req_o, mem_addr_o}, {1'b0, 32'h104});
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_async_axi", rsp, '0);
    chk("rst_async_mem", {mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o}, '0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    held = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (rsp.r_valid || rsp.b_valid) held++;
    end
    chk("rst_no_late_resp", held, 0);
    rsp_delay = 1;
    do_read(32'h104, 0, data, resp, lat, stable);
    chk("post_rst_read", {resp, data}, {RESP_OKAY, ref_read(32'h104)});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
